// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode values and FSM state encoding.
package alu_pkg;

    // Operation codes carried on ULAcontrol
    localparam int unsigned OP_AND   = 0;
    localparam int unsigned OP_OR    = 1;
    localparam int unsigned OP_ADD   = 2;
    localparam int unsigned OP_MULTU = 3;
    localparam int unsigned OP_DIVU  = 4;
    localparam int unsigned OP_SLTU  = 5;
    localparam int unsigned OP_SUB   = 6;
    localparam int unsigned OP_SLT   = 7;
    localparam int unsigned OP_XOR   = 8;
    localparam int unsigned OP_SLL   = 9;
    localparam int unsigned OP_SRL   = 10;
    localparam int unsigned OP_SRA   = 11;
    localparam int unsigned OP_NOR   = 12;

    // Control FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_multiciclo_if.sv
// Request/result bundle between the control FSM / register file and the ALU.
interface alu_multiciclo_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
);
    logic              start;
    logic [CTRL_W-1:0] ULAcontrol;
    logic [WIDTH-1:0]  entradaA;
    logic [WIDTH-1:0]  entradaB;
    logic [WIDTH-1:0]  saida;
    logic [WIDTH-1:0]  saida_hi;
    logic              zero;
    logic              overflow;
    logic              busy;
    logic              ready;
    logic              done;

    modport master (
        output start, ULAcontrol, entradaA, entradaB,
        input  saida, saida_hi, zero, overflow, busy, ready, done
    );

    modport slave (
        input  start, ULAcontrol, entradaA, entradaB,
        output saida, saida_hi, zero, overflow, busy, ready, done
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// res_hi/res_lo present the result of the step taken at the next edge, so the
// caller can capture the final value on the same edge as the last step.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    // hi:lo is product accumulator (mul) or remainder:quotient-shift (div)
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

    // One multiply or divide step computed from the current registers
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow
        div_fits = ~div_diff[WIDTH];
        div_hi   = div_fits ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_lo   = {lo_q[WIDTH-2:0], div_fits};
        res_hi   = div_q ? div_hi : mul_hi;
        res_lo   = div_q ? div_lo : mul_lo;
        last     = (cnt_q == '0);
    end

    // Operand load and per-step register update
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= is_div ? a : b;
            opnd_q <= is_div ? b : a;
            div_q  <= is_div;
            cnt_q  <= CW'(WIDTH - 1);
        end else if (step) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
            if (!last) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Registered multicycle ALU: single-cycle ops finish in one cycle, MULTU/DIVU
// iterate WIDTH cycles in muldiv_iter. Outputs only change on entry to FIN.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    alu_multiciclo_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0] saida_q, saida_d, hi_q, hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic             busy_q, done_q, ready_q;

    logic [WIDTH-1:0] a, b, add_res, sub_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_ovf;
    logic             op_mul, op_div, b_zero;
    logic             upd_sc, upd_md;

    logic             md_load, md_step, md_last;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign a       = bus.entradaA;
    assign b       = bus.entradaB;
    assign add_res = a + b;
    assign sub_res = a - b;
    assign shamt   = b[SHW-1:0];
    assign op_mul  = (bus.ULAcontrol == CTRL_W'(OP_MULTU));
    assign op_div  = (bus.ULAcontrol == CTRL_W'(OP_DIVU));
    assign b_zero  = (b == '0);

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .load   (md_load),
        .step   (md_step),
        .is_div (op_div),
        .a      (a),
        .b      (b),
        .last   (md_last),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Single-cycle results; DIVU here only covers the divide-by-zero shortcut
    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        case (bus.ULAcontrol)
            CTRL_W'(OP_AND): sc_lo = a & b;
            CTRL_W'(OP_OR):  sc_lo = a | b;
            CTRL_W'(OP_NOR): sc_lo = ~(a | b);
            CTRL_W'(OP_XOR): sc_lo = a ^ b;
            CTRL_W'(OP_ADD): begin
                sc_lo  = add_res;
                sc_ovf = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
            end
            CTRL_W'(OP_SUB): begin
                sc_lo  = sub_res;
                sc_ovf = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
            end
            CTRL_W'(OP_SLT):  sc_lo = WIDTH'($signed(a) < $signed(b));
            CTRL_W'(OP_SLTU): sc_lo = WIDTH'(a < b);
            CTRL_W'(OP_SLL):  sc_lo = a << shamt;
            CTRL_W'(OP_SRL):  sc_lo = a >> shamt;
            CTRL_W'(OP_SRA):  sc_lo = $signed(a) >>> shamt;
            CTRL_W'(OP_DIVU): begin
                sc_lo = '1;
                sc_hi = a;
            end
            default: ;
        endcase
    end

    // FSM next state and result-register next values
    always_comb begin
        state_d  = state_q;
        md_load  = 1'b0;
        md_step  = 1'b0;
        upd_sc   = 1'b0;
        upd_md   = 1'b0;
        saida_d  = saida_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StFin: begin
                if (bus.start) begin
                    if (op_mul || (op_div && !b_zero)) begin
                        md_load = 1'b1;
                        state_d = StRun;
                    end else begin
                        upd_sc  = 1'b1;
                        state_d = StFin;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                md_step = 1'b1;
                if (md_last) begin
                    upd_md  = 1'b1;
                    state_d = StFin;
                end
            end
            default: state_d = StIdle;
        endcase

        if (upd_sc) begin
            saida_d = sc_lo;
            hi_d    = sc_hi;
            zero_d  = (sc_lo == '0);
            ovf_d   = sc_ovf;
        end else if (upd_md) begin
            saida_d = md_lo;
            hi_d    = md_hi;
            zero_d  = (md_lo == '0);
            ovf_d   = 1'b0;
        end
    end

    // State, result and status registers; status flags follow the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            saida_q <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            saida_q <= saida_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StFin);
            ready_q <= (state_d != StRun);
        end
    end

    assign bus.saida    = saida_q;
    assign bus.saida_hi = hi_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ready    = ready_q;

endmodule
